rom_boot_loader: RTL and testbench
==================================

Name: rom_boot_loader

Overview:
- Sits between the mist_io ioctl download port and the zsdram write port, in the clk_sys domain.
- Accepts ROM bytes while ioctl_index==0, maps each 16 KB slot to its SDRAM bank, and buffers writes in a small FIFO. Each buffered write is issued to SDRAM with a request/acknowledge handshake.
- Holds the machine in reset for the whole load plus a fixed tail, and reports which ROM slots were filled.

Parameters:
- FIFO_AW, 2, log2 of FIFO depth (depth 4 entries of {addr[22:0], data[7:0]}).
- HOLD_CYCLES, 1024, clk_sys cycles that cpu_reset stays asserted after the FIFO drains.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous active-high reset
- ioctl_download  in  1  download in progress
- ioctl_index  in  8  download target; ROM load when 0
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte offset in download
- ioctl_dout  in  8  byte data
- boot_wr  out  1  SDRAM write request, level
- boot_a  out  23  SDRAM byte address
- boot_dout  out  8  SDRAM write data
- boot_ack  in  1  one-cycle pulse: SDRAM accepted current request
- cpu_reset  out  1  reset request to motherboard
- rom_valid  out  3  bit n set = slot n received at least one byte
- overflow  out  1  sticky: byte dropped because FIFO was full
- busy  out  1  state != IDLE

Behaviour:
- Reset values: boot_wr=0, boot_a=0, boot_dout=0, cpu_reset=0, rom_valid=0, overflow=0, busy=0. FIFO is emptied and the hold counter cleared. State becomes IDLE.
- A reset mid-load abandons all queued entries with no further boot_wr. A boot_ack arriving during or after reset is ignored.
- rom_load = ioctl_download & (ioctl_index==0).
- Address map, by slot = ioctl_addr[24:14]; boot_a[13:0] = ioctl_addr[13:0]:
  - slot 0 -> bank 9'h000
  - slot 1 -> bank 9'h100
  - slot 2 -> bank 9'h107
  - any other slot: byte discarded. It is not queued, does not set overflow, and does not touch rom_valid.
- Enqueue happens on the cycle with ioctl_wr & rom_load & mapped slot & FIFO not full. rom_valid[slot] is set on that same cycle.
- If the FIFO is full, the byte is dropped and overflow is set (sticky until reset).
- Simultaneous enqueue and dequeue on a full FIFO: both are accepted and the byte is not dropped.
- Output stage:
  - boot_wr/boot_a/boot_dout are driven from the FIFO head, registered.
  - A head entry is presented the cycle after it becomes available.
  - boot_wr stays high and boot_a/boot_dout stay stable until boot_ack.
  - On boot_ack the entry is popped. If the FIFO holds another entry, boot_wr stays high and the next entry appears the following cycle. Otherwise boot_wr drops the cycle after ack.
  - boot_ack while boot_wr=0 is ignored.
- Pointers wrap modulo 2^FIFO_AW. The count register is FIFO_AW+1 bits so full and empty are distinguished.
- State machine:
  - IDLE: cpu_reset=0. Entered from reset. Goes to LOAD on the rising edge of rom_load; the same cycle clears rom_valid and overflow.
  - LOAD: cpu_reset=1. Goes to DRAIN when rom_load falls.
  - DRAIN: cpu_reset=1. No new bytes are accepted (ioctl_wr ignored). Goes to HOLD when the FIFO is empty and boot_wr=0; the hold counter loads HOLD_CYCLES-1.
  - HOLD: cpu_reset=1. Counter decrements each cycle; goes to IDLE when it reaches 0. So cpu_reset stays high for exactly HOLD_CYCLES cycles after DRAIN ends.
  - A new rising edge of rom_load in HOLD returns to LOAD without clearing rom_valid.
- cpu_reset is registered and follows the state with 1 cycle of latency.
- Downloads with ioctl_index != 0 are fully ignored in every state.

Test Plan:
- Load of 3×16384 bytes, with boot_ack returned 2 cycles after each boot_wr:
  - byte at ioctl_addr 0x4005 is written to boot_a 0x400005;
  - byte at ioctl_addr 0x8000 is written to boot_a 0x41C000;
  - rom_valid=3'b111, overflow=0, all 49152 writes seen.
- Byte at ioctl_addr 0xC000 (slot 3) -> no boot_wr; rom_valid[3] does not exist, so bits stay unchanged; overflow stays 0.
- boot_ack withheld while 5 bytes arrive, FIFO_AW=2 -> 4 bytes queued; the 5th is dropped and overflow=1. After acks, exactly 4 writes occur, in order.
- ioctl_download falls with 3 entries queued, HOLD_CYCLES=16:
  - cpu_reset stays 1 until the third ack;
  - it then remains 1 for exactly 16 more cycles and deasserts (plus 1 cycle of registration latency);
  - busy falls together with the state returning to IDLE.
- reset asserted while boot_wr=1 with 2 entries queued -> next cycle boot_wr=0, cpu_reset=0, busy=0, FIFO empty; a later boot_ack produces no pop.
- Download with ioctl_index=1 (disk) -> no boot_wr, cpu_reset stays 0, and rom_valid is unchanged from the prior load.

Source files
------------

// File: rtl/rom_boot_loader.sv
// ROM download bridge: maps ioctl ROM bytes to SDRAM banks, queues them in a small FIFO,
// issues each write with a req/ack handshake and holds the machine in reset around the load.
module rom_boot_loader #(
  parameter int FIFO_AW     = 2,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        boot_wr,
  output logic [22:0] boot_a,
  output logic [7:0]  boot_dout,
  input  logic        boot_ack,
  output logic        cpu_reset,
  output logic [2:0]  rom_valid,
  output logic        overflow,
  output logic        busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int HW    = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [HW-1:0]     hold_reg, hold_next;
  logic [2:0]        rom_valid_reg, rom_valid_next;
  logic              overflow_reg, overflow_next;
  logic              rom_load_reg;
  logic              cpu_reset_reg;

  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg, count_next, remain;
  logic [FIFO_AW-1:0] head_idx;

  logic [22:0] mem_addr [DEPTH];
  logic [7:0]  mem_data [DEPTH];

  logic        boot_wr_reg;
  logic [22:0] boot_a_reg;
  logic [7:0]  boot_dout_reg;

  logic        rom_load, rom_load_rise;
  logic [8:0]  bank;
  logic [2:0]  slot_hot;
  logic        mapped, byte_ok, full, push, pop, drop, load_out;

  assign rom_load      = ioctl_download & (ioctl_index == 8'd0);
  assign rom_load_rise = rom_load & ~rom_load_reg;

  always_comb begin
    bank     = 9'h000;
    slot_hot = 3'b000;
    case (ioctl_addr[24:14])
      11'd0: begin bank = 9'h000; slot_hot = 3'b001; end
      11'd1: begin bank = 9'h100; slot_hot = 3'b010; end
      11'd2: begin bank = 9'h107; slot_hot = 3'b100; end
      default: ;
    endcase
  end

  assign mapped  = |slot_hot;
  assign byte_ok = ioctl_wr & rom_load & mapped & (state_reg != DRAIN);
  assign full    = (count_reg == (FIFO_AW + 1)'(DEPTH));
  // The presented entry stays in the FIFO until acknowledged, so boot_wr implies count > 0.
  assign pop     = boot_wr_reg & boot_ack;
  assign push    = byte_ok & (~full | pop);
  assign drop    = byte_ok & full & ~pop;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (FIFO_AW + 1)'(1);
      2'b01:   count_next = count_reg - (FIFO_AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Entries already in the FIFO after this cycle's pop; bytes pushed this cycle are not yet eligible.
  assign remain   = count_reg - {{FIFO_AW{1'b0}}, pop};
  assign head_idx = pop ? rd_ptr_reg + FIFO_AW'(1) : rd_ptr_reg;
  assign load_out = ~boot_wr_reg | pop;

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_addr[wr_ptr_reg] <= {bank, ioctl_addr[13:0]};
      mem_data[wr_ptr_reg] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      boot_wr_reg   <= 1'b0;
      boot_a_reg    <= 23'd0;
      boot_dout_reg <= 8'd0;
    end else if (load_out) begin
      boot_wr_reg <= (remain != '0);
      if (remain != '0) begin
        boot_a_reg    <= mem_addr[head_idx];
        boot_dout_reg <= mem_data[head_idx];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    rom_valid_next = rom_valid_reg;
    overflow_next  = overflow_reg;
    case (state_reg)
      IDLE: begin
        if (rom_load_rise) begin
          state_next     = LOAD;
          rom_valid_next = 3'b000;
          overflow_next  = 1'b0;
        end
      end
      LOAD: begin
        if (!rom_load) state_next = DRAIN;
      end
      DRAIN: begin
        if (count_reg == '0 && !boot_wr_reg) begin
          state_next = HOLD;
          hold_next  = HW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        // A new ROM download restarts loading but keeps the slots already received.
        if (rom_load_rise)        state_next = LOAD;
        else if (hold_reg == '0)  state_next = IDLE;
        else                      hold_next  = hold_reg - HW'(1);
      end
      default: state_next = IDLE;
    endcase
    if (push) rom_valid_next = rom_valid_next | slot_hot;
    if (drop) overflow_next  = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      rom_valid_reg <= 3'b000;
      overflow_reg  <= 1'b0;
      rom_load_reg  <= 1'b0;
      cpu_reset_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      rom_valid_reg <= rom_valid_next;
      overflow_reg  <= overflow_next;
      rom_load_reg  <= rom_load;
      cpu_reset_reg <= (state_reg != IDLE);
    end
  end

  assign boot_wr   = boot_wr_reg;
  assign boot_a    = boot_a_reg;
  assign boot_dout = boot_dout_reg;
  assign cpu_reset = cpu_reset_reg;
  assign rom_valid = rom_valid_reg;
  assign overflow  = overflow_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed bench for rom_boot_loader: table-driven load plus hand sequences for
// overflow, drain/hold timing, reset abort and non-ROM downloads.
module tb_rom_boot_loader;
  localparam int HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [7:0]  boot_dout;
  logic        boot_ack;
  logic        cpu_reset;
  logic [2:0]  rom_valid;
  logic        overflow;
  logic        busy;

  logic auto_ack = 1'b0;
  logic man_ack = 1'b0;
  bit   ack_en = 1'b0;
  int   wait_cnt = 0;
  assign boot_ack = auto_ack | man_ack;

  int total = 0;
  int bad = 0;

  typedef struct packed {logic [22:0] a; logic [7:0] d;} wr_t;
  wr_t got[$];
  wr_t expq[$];

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        keep;
    logic [22:0] exp_a;
  } vec_t;
  vec_t vecs[10];

  always #5 clk_sys = ~clk_sys;

  rom_boot_loader #(.FIFO_AW(2), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .boot_wr(boot_wr), .boot_a(boot_a),
    .boot_dout(boot_dout), .boot_ack(boot_ack), .cpu_reset(cpu_reset),
    .rom_valid(rom_valid), .overflow(overflow), .busy(busy)
  );

  // SDRAM model: acknowledges in the third cycle a request is presented.
  always @(negedge clk_sys) begin
    auto_ack = 1'b0;
    if (ack_en && boot_wr && !reset) begin
      if (wait_cnt == 2) begin
        auto_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Records every accepted write (request and ack in the same cycle).
  always begin
    @(negedge clk_sys);
    #1;
    if (!reset && boot_wr && boot_ack) got.push_back(wr_t'{boot_a, boot_dout});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
    end else begin
      $display("ok   %s = %0h", name, got_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick(2);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || cpu_reset) && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check({name, " reached idle"}, 32'(n < 2000), 32'd1);
  endtask

  task automatic expect_wr(input logic [22:0] a, input logic [7:0] d);
    expq.push_back(wr_t'{a, d});
  endtask

  task automatic compare_writes(input string name);
    check({name, " write count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      check($sformatf("%s wr%0d addr", name, i), got[i].a, expq[i].a);
      check($sformatf("%s wr%0d data", name, i), got[i].d, expq[i].d);
    end
    got.delete();
    expq.delete();
  endtask

  initial begin
    int n;
    int bn;
    int n0;

    vecs[0] = '{25'h0000000, 8'h11, 1'b1, 23'h000000};
    vecs[1] = '{25'h0003FFF, 8'h22, 1'b1, 23'h003FFF};
    vecs[2] = '{25'h0004005, 8'h33, 1'b1, 23'h400005};
    vecs[3] = '{25'h0007FFF, 8'h44, 1'b1, 23'h403FFF};
    vecs[4] = '{25'h0008000, 8'h55, 1'b1, 23'h41C000};
    vecs[5] = '{25'h000BFFF, 8'h66, 1'b1, 23'h41FFFF};
    vecs[6] = '{25'h000C000, 8'h77, 1'b0, 23'h000000};
    vecs[7] = '{25'h1FFFFFF, 8'h88, 1'b0, 23'h000000};
    vecs[8] = '{25'h0004000, 8'h99, 1'b1, 23'h400000};
    vecs[9] = '{25'h000A5A5, 8'hAA, 1'b1, 23'h41E5A5};

    // Reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst boot_wr", boot_wr, 0);
    check("rst boot_a", boot_a, 0);
    check("rst boot_dout", boot_dout, 0);
    check("rst cpu_reset", cpu_reset, 0);
    check("rst rom_valid", rom_valid, 0);
    check("rst overflow", overflow, 0);
    check("rst busy", busy, 0);

    // Table-driven ROM load across all three slots plus unmapped bytes
    ack_en = 1'b1;
    start_dl(8'd0);
    check("load busy", busy, 1);
    check("load cpu_reset", cpu_reset, 1);
    for (int i = 0; i < 10; i++) begin
      send_byte(vecs[i].addr, vecs[i].data);
      tick(3);
      if (vecs[i].keep) expect_wr(vecs[i].exp_a, vecs[i].data);
    end
    ioctl_download = 1'b0;
    wait_idle("table");
    compare_writes("table");
    check("table rom_valid", rom_valid, 3'b111);
    check("table overflow", overflow, 0);

    // Slot 3 byte alone: no write, rom_valid untouched
    start_dl(8'd0);
    send_byte(25'h000C000, 8'hC3);
    tick(4);
    check("slot3 rom_valid", rom_valid, 3'b000);
    check("slot3 boot_wr", boot_wr, 0);
    check("slot3 writes", got.size(), 0);
    check("slot3 overflow", overflow, 0);
    send_byte(25'h0000010, 8'h3C);
    tick(3);
    ioctl_download = 1'b0;
    wait_idle("slot3");
    expect_wr(23'h000010, 8'h3C);
    compare_writes("slot3");
    check("slot3 rom_valid end", rom_valid, 3'b001);

    // Acks withheld: 4 bytes queue, the 5th is dropped
    ack_en = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 5; i++) send_byte(25'h0000100 + 25'(i), 8'hA0 + 8'(i));
    tick(1);
    check("ovf overflow", overflow, 1);
    check("ovf boot_wr", boot_wr, 1);
    check("ovf head addr", boot_a, 23'h000100);
    tick(3);
    check("ovf head stable", boot_a, 23'h000100);
    check("ovf data stable", boot_dout, 8'hA0);
    ack_en = 1'b1;
    ioctl_download = 1'b0;
    wait_idle("ovf");
    for (int i = 0; i < 4; i++) expect_wr(23'h000100 + 23'(i), 8'hA0 + 8'(i));
    compare_writes("ovf");
    check("ovf sticky", overflow, 1);

    // Full FIFO with push and pop in the same cycle: byte accepted
    ack_en = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 4; i++) send_byte(25'h0000200 + 25'(i), 8'hB0 + 8'(i));
    tick(1);
    man_ack    = 1'b1;
    ioctl_addr = 25'h0000204;
    ioctl_dout = 8'hB4;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    man_ack  = 1'b0;
    ioctl_wr = 1'b0;
    tick(1);
    check("fullpp overflow", overflow, 0);
    check("fullpp head", boot_a, 23'h000201);
    ack_en = 1'b1;
    ioctl_download = 1'b0;
    wait_idle("fullpp");
    for (int i = 0; i < 5; i++) expect_wr(23'h000200 + 23'(i), 8'hB0 + 8'(i));
    compare_writes("fullpp");

    // Drain with 3 entries, then HOLD timing
    ack_en = 1'b0;
    start_dl(8'd0);
    for (int i = 0; i < 3; i++) send_byte(25'h0004000 + 25'(i), 8'hC0 + 8'(i));
    tick(2);
    ioctl_download = 1'b0;
    tick(3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain cpu_reset ack%0d", k), cpu_reset, 1);
      check($sformatf("drain boot_wr ack%0d", k), boot_wr, 1);
      man_ack = 1'b1;
      @(negedge clk_sys);
      man_ack = 1'b0;
      if (k < 2) @(negedge clk_sys);
    end
    // One cycle to see the drained FIFO, HOLD cycles, then one cycle of cpu_reset latency.
    n  = 0;
    bn = 0;
    while (cpu_reset && n < 100) begin
      if (busy) bn++;
      n++;
      @(negedge clk_sys);
    end
    check("hold cpu_reset cycles", n, HOLD + 2);
    check("hold busy cycles", bn, HOLD + 1);
    check("hold busy end", busy, 0);
    expect_wr(23'h400000, 8'hC0);
    expect_wr(23'h400001, 8'hC1);
    expect_wr(23'h400002, 8'hC2);
    compare_writes("hold");

    // Reset with a request outstanding and another queued
    start_dl(8'd0);
    send_byte(25'h0000300, 8'hD0);
    send_byte(25'h0000301, 8'hD1);
    tick(2);
    check("rstq boot_wr before", boot_wr, 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("rstq boot_wr", boot_wr, 0);
    check("rstq cpu_reset", cpu_reset, 0);
    check("rstq busy", busy, 0);
    check("rstq boot_a", boot_a, 0);
    check("rstq rom_valid", rom_valid, 0);
    reset = 1'b0;
    n0 = got.size();
    man_ack = 1'b1;
    @(negedge clk_sys);
    man_ack = 1'b0;
    tick(4);
    check("rstq boot_wr after ack", boot_wr, 0);
    check("rstq no writes", got.size(), n0);
    got.delete();

    // ioctl_index=1 download is ignored
    ack_en = 1'b1;
    start_dl(8'd0);
    send_byte(25'h0008001, 8'h5C);
    tick(3);
    ioctl_download = 1'b0;
    wait_idle("disk prep");
    expect_wr(23'h41C001, 8'h5C);
    compare_writes("disk prep");
    check("disk prep rom_valid", rom_valid, 3'b100);
    start_dl(8'd1);
    send_byte(25'h0000000, 8'hE0);
    send_byte(25'h0004000, 8'hE1);
    tick(4);
    check("disk cpu_reset", cpu_reset, 0);
    check("disk busy", busy, 0);
    check("disk boot_wr", boot_wr, 0);
    check("disk rom_valid", rom_valid, 3'b100);
    ioctl_download = 1'b0;
    tick(4);
    check("disk writes", got.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
